ucsbece154a_mc_controller: RTL

- Multicycle RV32I-subset controller; successor to the single-cycle main/ALU decoder.
- Sequences each instruction through a Moore FSM driving the shared-memory multicycle datapath (IR, OldPC, A/B, ALUOut, Data registers).
- Adds parametrised memory wait states, a sticky illegal-opcode trap and a retired-instruction counter.
- Supports lw, sw, R-type (add/sub/slt/or/and), I-type ALU, beq, jal and lui.

---
 rtl/ucsbece154a_mc_controller_if.sv | 37 +++
 rtl/ucsbece154a_mc_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller is the master: it consumes the decoded instruction fields and the zero flag, and drives every strobe and mux select.
interface ucsbece154a_mc_controller_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       op_i;
    logic [2:0]       funct3_i;
    logic             funct7b5_i;
    logic             Zero_i;
    logic             PCWrite_o;
    logic             AdrSrc_o;
    logic             MemWrite_o;
    logic             IRWrite_o;
    logic [1:0]       ResultSrc_o;
    logic [1:0]       ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic [2:0]       ImmSrc_o;
    logic [2:0]       ALUControl_o;
    logic             RegWrite_o;
    logic             Illegal_o;
    logic [CNT_W-1:0] Retired_o;
    logic [3:0]       State_o;

    modport master (
        input  op_i, funct3_i, funct7b5_i, Zero_i,
        output PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o,
               ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUControl_o, RegWrite_o,
               Illegal_o, Retired_o, State_o
    );

    modport slave (
        output op_i, funct3_i, funct7b5_i, Zero_i,
        input  PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o,
               ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUControl_o, RegWrite_o,
               Illegal_o, Retired_o, State_o
    );
endinterface

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RV32I-subset controller: Moore FSM with memory wait states,
// a sticky illegal-opcode trap and a retired-instruction counter.
module ucsbece154a_mc_controller #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    ucsbece154a_mc_controller_if.master    bus
);
    localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE   = 4'd1,  MEMADR   = 4'd2,  MEMREAD = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5,  EXECUTER = 4'd6,  EXECUTEI = 4'd7,
        ALUWB    = 4'd8,  BEQ      = 4'd9,  JAL      = 4'd10, LUI     = 4'd11,
        ERROR    = 4'd12
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

    state_t             state_reg;
    logic [WAIT_W-1:0]  wait_reg;
    logic [CNT_W-1:0]   retired_reg;

    logic    wait_done;
    logic    in_mem_state;
    assign wait_done    = (wait_reg == '0);
    assign in_mem_state = (state_reg == FETCH) || (state_reg == MEMREAD) ||
                          (state_reg == MEMWRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            wait_reg    <= WAIT_INIT;
            retired_reg <= '0;
        end else begin
            // The counter only runs down inside a memory state; anywhere else it
            // sits at the preload so the next memory state starts fresh.
            if (in_mem_state && !wait_done)
                wait_reg <= wait_reg - WAIT_W'(1);
            else
                wait_reg <= WAIT_INIT;

            case (state_reg)
                FETCH:    if (wait_done) state_reg <= DECODE;
                DECODE: begin
                    case (bus.op_i)
                        OP_LW, OP_SW: state_reg <= MEMADR;
                        OP_R:         state_reg <= EXECUTER;
                        OP_I:         state_reg <= EXECUTEI;
                        OP_BEQ:       state_reg <= BEQ;
                        OP_JAL:       state_reg <= JAL;
                        OP_LUI:       state_reg <= LUI;
                        default:      state_reg <= ERROR;
                    endcase
                end
                MEMADR:   state_reg <= (bus.op_i == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD:  if (wait_done) state_reg <= MEMWB;
                MEMWRITE: begin
                    if (wait_done) begin
                        state_reg   <= FETCH;
                        retired_reg <= retired_reg + CNT_W'(1);
                    end
                end
                EXECUTER, EXECUTEI, JAL: state_reg <= ALUWB;
                MEMWB, ALUWB, BEQ, LUI: begin
                    state_reg   <= FETCH;
                    retired_reg <= retired_reg + CNT_W'(1);
                end
                ERROR:    state_reg <= ERROR;
                default:  state_reg <= ERROR;
            endcase
        end
    end

    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    alu_op_t    alu_op;

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        case (state_reg)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = wait_done;
                pc_write   = wait_done;
            end
            DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
            MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
            MEMREAD:  adr_src = 1'b1;
            MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
            MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
            EXECUTER: begin alu_src_a = 2'b10; alu_op = ALUOP_FUNCT; end
            EXECUTEI: begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = ALUOP_FUNCT; end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                pc_write  = bus.Zero_i;
            end
            JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
            LUI:      begin result_src = 2'b11; reg_write = 1'b1; end
            default:  ;
        endcase
    end

    logic [2:0] alu_control;
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            ALUOP_SUB:   alu_control = 3'b001;
            ALUOP_FUNCT: begin
                case (bus.funct3_i)
                    // op[5] separates R-type sub from addi with a stray imm bit 10.
                    3'b000:  alu_control = (bus.funct7b5_i & bus.op_i[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default:     alu_control = 3'b000;
        endcase
    end

    logic [2:0] imm_src;
    always_comb begin
        imm_src = 3'b000;
        case (bus.op_i)
            OP_SW:   imm_src = 3'b001;
            OP_BEQ:  imm_src = 3'b010;
            OP_JAL:  imm_src = 3'b011;
            OP_LUI:  imm_src = 3'b100;
            default: imm_src = 3'b000;
        endcase
    end

    // Write strobes are forced low while reset is held so nothing is committed.
    assign bus.PCWrite_o    = pc_write  & ~reset;
    assign bus.MemWrite_o   = mem_write & ~reset;
    assign bus.IRWrite_o    = ir_write  & ~reset;
    assign bus.RegWrite_o   = reg_write & ~reset;
    assign bus.AdrSrc_o     = adr_src;
    assign bus.ResultSrc_o  = result_src;
    assign bus.ALUSrcA_o    = alu_src_a;
    assign bus.ALUSrcB_o    = alu_src_b;
    assign bus.ALUControl_o = alu_control;
    assign bus.ImmSrc_o     = imm_src;
    assign bus.Illegal_o    = (state_reg == ERROR);
    assign bus.Retired_o    = retired_reg;
    assign bus.State_o      = state_reg;
endmodule
